// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - RV32M iterative multiply/divide unit with fixed 34-cycle latency.
// One shared 64-bit accumulator serves both shift-add multiply and restoring divide.
module mul_div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc;
  logic [5:0]  count;
  logic        neg_a;
  logic        neg_b;
  logic        div_zero;

  logic        a_signed;
  logic        b_signed;
  logic        in_neg_a;
  logic        in_neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_step;

  logic        sign_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result_fix;

  // Operand decode: magnitudes are kept unsigned 32-bit, so 0x80000000 maps to 2^31 exactly.
  always_comb begin
    a_signed = FUNCT3[2] ? ~FUNCT3[0] : (FUNCT3[1:0] != 2'b11);
    b_signed = FUNCT3[2] ? ~FUNCT3[0] : ~FUNCT3[1];
    in_neg_a = a_signed & DATA1[31];
    in_neg_b = b_signed & DATA2[31];
    abs_a    = in_neg_a ? -DATA1 : DATA1;
    abs_b    = in_neg_b ? -DATA2 : DATA2;
  end

  // Multiply: {hi, lo=multiplier} shifts right, adding the multiplicand into hi on lo[0].
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    mul_step = {mul_sum, acc[31:1]};
  end

  // Divide: {hi=remainder, lo=dividend/quotient} shifts left one bit per step.
  always_comb begin
    div_shift = {acc[63:32], acc[31]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[31:0] - mag_b;
    div_step  = div_ge ? {div_diff, acc[30:0], 1'b1}
                       : {div_shift[31:0], acc[30:0], 1'b0};
  end

  // Divide-by-zero leaves an all-ones quotient, which must not be sign-flipped.
  always_comb begin
    sign_diff = neg_a ^ neg_b;
    prod_fix  = sign_diff ? -acc : acc;
    quo_fix   = (sign_diff && !div_zero) ? -acc[31:0] : acc[31:0];
    rem_fix   = neg_a ? -acc[63:32] : acc[63:32];
    case (op)
      3'b000:                 result_fix = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: result_fix = prod_fix[63:32];
      3'b100, 3'b101:         result_fix = quo_fix;
      default:                result_fix = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = CALC;
      CALC:    if (count == 6'd32) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
    DONE = (state == FINISH);
  end

  // RESULT is loaded on the CALC->FINISH edge so it is valid during the DONE cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op       <= 3'b000;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      acc      <= 64'd0;
      count    <= 6'd0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      RESULT   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            op       <= FUNCT3;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            div_zero <= (DATA2 == 32'd0);
            count    <= 6'd0;
            acc      <= FUNCT3[2] ? {32'd0, abs_a} : {32'd0, abs_b};
          end
        end
        CALC: begin
          if (count != 6'd32) begin
            acc   <= op[2] ? div_step : mul_step;
            count <= count + 6'd1;
          end else begin
            RESULT <= result_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001: The block SHALL use a single clock, and its reset SHALL be synchronous and active-high.
REQ-002: CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-003: RESET  input  1  synchronous, active-high reset.
REQ-004: START  input  1  request pulse; it SHALL be sampled only while the unit is idle.
REQ-005: FUNCT3  input  3  RV32M operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006: DATA1  input  32  operand A (rs1).
REQ-007: DATA2  input  32  operand B, driven by the execute-stage 32-bit operand mux output.
REQ-008: BUSY  output  1  high from the cycle after an accepted START until DONE, inclusive.
REQ-009: DONE  output  1  single-cycle pulse marking RESULT valid.
REQ-010: RESULT  output  32  operation result; it SHALL be held stable from DONE until the next accepted START.

Function
REQ-011: States SHALL be IDLE, CALC and FINISH, and only these.
REQ-012: IDLE: START=1 -> latch FUNCT3, DATA1 and DATA2; load |A| and |B| per signedness; clear the 6-bit iteration counter; go to CALC.
REQ-013: IDLE: START=0 -> remain in IDLE.
REQ-014: START, FUNCT3, DATA1 and DATA2 SHALL be ignored in CALC and FINISH; a START asserted there is dropped, not queued.
REQ-015: Signedness: MUL, MULH and DIV/REM treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU, DIVU and REMU treat both as unsigned.
REQ-016: CALC (multiply) SHALL perform exactly 32 shift-add iterations on magnitudes into a 64-bit product register.
REQ-017: CALC (divide) SHALL perform exactly 32 restoring shift-subtract iterations producing a 32-bit quotient and a 32-bit remainder.
REQ-018: CALC SHALL exit to FINISH when the counter reaches 32.
REQ-019: FINISH SHALL apply sign correction: product negated iff sign(A) XOR sign(B) over the signed operands; quotient negated iff the signs differ; remainder takes the sign of the dividend.
REQ-020: FINISH SHALL register RESULT and assert DONE for exactly one cycle, then go to IDLE.
REQ-021: RESULT selection SHALL be: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-022: Latency SHALL be fixed: START accepted at edge T gives DONE high in the cycle after edge T+33, for every FUNCT3 and operand value.
REQ-023: A new START SHALL be accepted in the cycle in which DONE is low and BUSY is low, i.e. the cycle after DONE at the earliest.
REQ-024: Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> DATA1. No trap is raised, and latency is unchanged.
REQ-025: Signed overflow (DIV with 0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and REM result 0x00000000, with latency unchanged.
REQ-026: Operand 0x80000000 SHALL be handled as magnitude 2^31 without loss, which requires 33-bit internal magnitude handling or an equivalent.

Reset
REQ-027: RESET=1 at any rising edge SHALL force IDLE, clear the counter and internal registers, and set BUSY=0, DONE=0 and RESULT=0x00000000.
REQ-028: RESET during CALC or FINISH SHALL abort the operation with no DONE pulse, and the unit SHALL accept START on the first cycle after RESET deasserts.
REQ-029: If RESET and START are both high in the same cycle, RESET SHALL win and START SHALL be dropped.

Verification
REQ-030: MUL, DATA1=0x00000007, DATA2=0xFFFFFFFD (-3) -> RESULT=0xFFFFFFEB, with DONE exactly 34 cycles after START.
REQ-031: MULH with 0x80000000 x 0x80000000 -> 0x40000000; MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
REQ-033: DIV by zero with DATA1=0x12345678 -> 0xFFFFFFFF; REMU by zero -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0x00000000.
REQ-034: START pulsed again mid-CALC with different operands -> ignored; the first operation's RESULT is reported, and only one DONE pulse occurs.
REQ-035: RESET asserted 10 cycles into an operation -> BUSY=0, RESULT=0 and no DONE; a fresh MUL 3x5 started right after -> 0x0000000F in 34 cycles.
